// File: rtl/memory_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : memory_access_unit
// Description : Load/store lane steering. Builds bus address, size, byte
//               strobes and lane-aligned store data combinationally, captures
//               the raw bus read word and extracts/extends the load result.
//               Optional registered misalignment flag: MEM_MISALIGN_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module memory_access_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] address_req,
    input  logic [63:0] data_in,
    input  logic [2:0]  mem_mode,
    output logic [63:0] addr,
    output logic [2:0]  msize,
    output logic [7:0]  strobe,
    output logic [63:0] data,
    input  logic        resp_valid,
    input  logic [63:0] resp_data,
    output logic [63:0] load_data,
    output logic        misaligned
);

    localparam logic [2:0] c_MODE_SB = 3'b000;
    localparam logic [2:0] c_MODE_SH = 3'b001;
    localparam logic [2:0] c_MODE_SW = 3'b010;
    localparam logic [2:0] c_MODE_UB = 3'b100;
    localparam logic [2:0] c_MODE_UH = 3'b101;
    localparam logic [2:0] c_MODE_UW = 3'b110;

    logic [2:0]  w_off;
    logic [5:0]  w_shamt;
    logic [7:0]  w_base_mask;
    logic [15:0] w_strobe_wide;
    logic [63:0] w_shifted;
    logic [63:0] r_capture;

    assign w_off   = address_req[2:0];
    assign w_shamt = {w_off, 3'b000};

    // Request path: purely combinational, also during reset
    assign addr  = address_req;
    assign msize = {1'b0, mem_mode[1:0]};

    always_comb begin
        w_base_mask = 8'hFF;
        case (mem_mode[1:0])
            2'd0:    w_base_mask = 8'h01;
            2'd1:    w_base_mask = 8'h03;
            2'd2:    w_base_mask = 8'h0F;
            default: w_base_mask = 8'hFF;
        endcase
    end

    // Widened shift so lanes pushed past byte 7 fall off cleanly
    assign w_strobe_wide = {8'h00, w_base_mask} << w_off;
    assign strobe        = w_strobe_wide[7:0];
    assign data          = data_in << w_shamt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_capture <= 64'd0;
        end else if (resp_valid) begin
            r_capture <= resp_data;
        end
    end

    assign w_shifted = r_capture >> w_shamt;

    always_comb begin
        load_data = w_shifted;
        case (mem_mode)
            c_MODE_SB: load_data = {{56{w_shifted[7]}},  w_shifted[7:0]};
            c_MODE_SH: load_data = {{48{w_shifted[15]}}, w_shifted[15:0]};
            c_MODE_SW: load_data = {{32{w_shifted[31]}}, w_shifted[31:0]};
            c_MODE_UB: load_data = {56'd0, w_shifted[7:0]};
            c_MODE_UH: load_data = {48'd0, w_shifted[15:0]};
            c_MODE_UW: load_data = {32'd0, w_shifted[31:0]};
            default:   load_data = w_shifted;
        endcase
    end

`ifdef MEM_MISALIGN_CHECK_EN
    logic w_misalign_next;
    logic r_misaligned;

    always_comb begin
        w_misalign_next = 1'b0;
        case (mem_mode[1:0])
            2'd1:    w_misalign_next = w_off[0];
            2'd2:    w_misalign_next = |w_off[1:0];
            2'd3:    w_misalign_next = |w_off;
            default: w_misalign_next = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_misaligned <= 1'b0;
        end else begin
            r_misaligned <= w_misalign_next;
        end
    end

    // Masked so the flag reads 0 for the whole reset window, not just after the edge
    assign misaligned = r_misaligned & rst;
`else
    assign misaligned = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_memory_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_memory_access_unit
// Description : Self-checking bench for memory_access_unit against a
//               byte-level behavioural model plus literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_access_unit;

    logic        clk;
    logic        rst;
    logic [63:0] address_req;
    logic [63:0] data_in;
    logic [2:0]  mem_mode;
    logic [63:0] addr;
    logic [2:0]  msize;
    logic [7:0]  strobe;
    logic [63:0] data;
    logic        resp_valid;
    logic [63:0] resp_data;
    logic [63:0] load_data;
    logic        misaligned;

    int n_checks = 0;
    int n_fail   = 0;
    logic check_en = 1'b0;

    logic [63:0] m_cap;
    logic        m_mis;

    memory_access_unit dut (
        .clk         (clk),
        .rst         (rst),
        .address_req (address_req),
        .data_in     (data_in),
        .mem_mode    (mem_mode),
        .addr        (addr),
        .msize       (msize),
        .strobe      (strobe),
        .data        (data),
        .resp_valid  (resp_valid),
        .resp_data   (resp_data),
        .load_data   (load_data),
        .misaligned  (misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    function automatic int nbytes(input logic [2:0] m);
        case (m[1:0])
            2'd0:    return 1;
            2'd1:    return 2;
            2'd2:    return 4;
            default: return 8;
        endcase
    endfunction

    function automatic logic [7:0] exp_strobe(input logic [63:0] a, input logic [2:0] m);
        logic [7:0] s;
        int off;
        off = int'(a[2:0]);
        s = 8'h00;
        for (int i = 0; i < 8; i++)
            s[i] = (i >= off) && (i < off + nbytes(m));
        return s;
    endfunction

    function automatic logic [63:0] exp_data(input logic [63:0] a, input logic [63:0] d);
        logic [63:0] r;
        int off;
        off = int'(a[2:0]);
        r = 64'd0;
        for (int i = 0; i < 8; i++)
            if (i >= off) r[8*i +: 8] = d[8*(i-off) +: 8];
        return r;
    endfunction

    function automatic logic [63:0] exp_load(input logic [63:0] cap, input logic [63:0] a,
                                             input logic [2:0] m);
        logic [63:0] r;
        int off, n;
        logic sgn;
        off = int'(a[2:0]);
        n   = nbytes(m);
        r   = 64'd0;
        for (int j = 0; j < n; j++)
            if (off + j < 8) r[8*j +: 8] = cap[8*(off+j) +: 8];
        sgn = r[8*n-1];
        if (n < 8 && !m[2] && sgn)
            for (int j = n; j < 8; j++) r[8*j +: 8] = 8'hFF;
        return r;
    endfunction

    function automatic logic exp_misalign(input logic [63:0] a, input logic [2:0] m);
        return (int'(a[2:0]) % nbytes(m)) != 0;
    endfunction

    always @(posedge clk) begin
        if (!rst)            m_cap <= 64'd0;
        else if (resp_valid) m_cap <= resp_data;
        m_mis <= rst ? exp_misalign(address_req, mem_mode) : 1'b0;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%016h expected 0x%016h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (check_en) begin
            chk("addr",   addr, address_req);
            chk("msize",  {61'd0, msize}, 64'(nbytes(mem_mode) == 1 ? 0 :
                                             nbytes(mem_mode) == 2 ? 1 :
                                             nbytes(mem_mode) == 4 ? 2 : 3));
            chk("strobe", {56'd0, strobe}, {56'd0, exp_strobe(address_req, mem_mode)});
            chk("data",   data, exp_data(address_req, data_in));
            chk("load",   load_data, exp_load(m_cap, address_req, mem_mode));
`ifdef MEM_MISALIGN_CHECK_EN
            chk("misaligned", {63'd0, misaligned}, {63'd0, rst ? m_mis : 1'b0});
`else
            chk("misaligned", {63'd0, misaligned}, 64'd0);
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic r, input logic v, input logic [63:0] a,
                         input logic [63:0] d, input logic [63:0] rd, input logic [2:0] m);
        @(posedge clk);
        #1;
        rst = r; resp_valid = v; address_req = a; data_in = d; resp_data = rd; mem_mode = m;
    endtask

    task automatic settle;
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; resp_valid = 1'b1; address_req = 64'd0; data_in = 64'd0;
        resp_data = 64'hFFFF_FFFF_FFFF_FFFF; mem_mode = 3'b011;
        repeat (2) @(posedge clk);
        #1;
        check_en = 1'b1;
        settle();
        chk("reset_load", load_data, 64'd0);
        chk("reset_mis",  {63'd0, misaligned}, 64'd0);

        // byte access at offset 3
        drive(1, 1, 64'h1003, 64'hAB, 64'h0000_0000_FF00_0000, 3'b000);
        settle();
        chk("v1_msize",  {61'd0, msize}, 64'd0);
        chk("v1_strobe", {56'd0, strobe}, 64'h08);
        chk("v1_data",   data, 64'h0000_0000_AB00_0000);
        drive(1, 0, 64'h1003, 64'hAB, 64'd0, 3'b000);
        settle();
        chk("v1_lb",  load_data, 64'hFFFF_FFFF_FFFF_FFFF);
        drive(1, 0, 64'h1003, 64'hAB, 64'd0, 3'b100);
        settle();
        chk("v1_lbu", load_data, 64'h0000_0000_0000_00FF);

        // word access at offset 4
        drive(1, 1, 64'h2004, 64'h1234_5678_8765_4321, 64'h8000_0001_0000_0000, 3'b010);
        settle();
        chk("v2_strobe", {56'd0, strobe}, 64'hF0);
        chk("v2_data",   data, 64'h8765_4321_0000_0000);
        drive(1, 0, 64'h2004, 64'd0, 64'd0, 3'b010);
        settle();
        chk("v2_lw",  load_data, 64'hFFFF_FFFF_8000_0001);
        drive(1, 0, 64'h2004, 64'd0, 64'd0, 3'b110);
        settle();
        chk("v2_lwu", load_data, 64'h0000_0000_8000_0001);

        // half at offset 6, then double at offset 0
        drive(1, 1, 64'h3006, 64'd0, 64'h7FFF_0000_0000_0000, 3'b001);
        settle();
        chk("v3_strobe", {56'd0, strobe}, 64'hC0);
        drive(1, 0, 64'h3006, 64'd0, 64'd0, 3'b001);
        settle();
        chk("v3_lh", load_data, 64'h0000_0000_0000_7FFF);
        drive(1, 0, 64'h3000, 64'd0, 64'd0, 3'b011);
        settle();
        chk("v3_strobe_d", {56'd0, strobe}, 64'hFF);
        chk("v3_ld", load_data, 64'h7FFF_0000_0000_0000);
        drive(1, 0, 64'h3000, 64'd0, 64'd0, 3'b111);
        settle();
        chk("v3_ld_rsvd", load_data, 64'h7FFF_0000_0000_0000);

        // reset clears capture and ignores concurrent response
        drive(1, 1, 64'h0, 64'd0, 64'h0000_0000_DEAD_BEEF, 3'b011);
        drive(0, 1, 64'h0, 64'd0, 64'h1111_2222_3333_4444, 3'b011);
        settle();
        chk("v4_before_rst", load_data, 64'h0000_0000_DEAD_BEEF);
        chk("v4_mis_in_rst", {63'd0, misaligned}, 64'd0);
        drive(1, 0, 64'h0, 64'd0, 64'h5555_5555_5555_5555, 3'b011);
        settle();
        chk("v4_after_rst", load_data, 64'd0);
        drive(1, 0, 64'h0, 64'd0, 64'h5555_5555_5555_5555, 3'b000);
        settle();
        chk("v4_hold", load_data, 64'd0);

        // back-to-back responses: last wins
        drive(1, 1, 64'h0, 64'd0, 64'hAAAA_AAAA_AAAA_AAAA, 3'b011);
        drive(1, 1, 64'h0, 64'd0, 64'h0123_4567_89AB_CDEF, 3'b011);
        drive(1, 0, 64'h0, 64'd0, 64'd0, 3'b011);
        settle();
        chk("b2b_last", load_data, 64'h0123_4567_89AB_CDEF);

        // misalignment flag
        drive(1, 0, 64'h1002, 64'd0, 64'd0, 3'b010);
        drive(1, 0, 64'h1004, 64'd0, 64'd0, 3'b010);
        settle();
`ifdef MEM_MISALIGN_CHECK_EN
        chk("mis_1002_w", {63'd0, misaligned}, 64'd1);
`else
        chk("mis_1002_w", {63'd0, misaligned}, 64'd0);
`endif
        drive(1, 0, 64'h1001, 64'd0, 64'd0, 3'b000);
        settle();
        chk("mis_1004_w", {63'd0, misaligned}, 64'd0);
        drive(1, 0, 64'h1000, 64'd0, 64'd0, 3'b000);
        settle();
        chk("mis_1001_b", {63'd0, misaligned}, 64'd0);

        // randomized traffic checked by the per-cycle compare
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 19) != 0),
                  $urandom_range(0, 1) == 1,
                  {$urandom, $urandom},
                  {$urandom, $urandom},
                  {$urandom, $urandom},
                  3'($urandom_range(0, 7)));
        end
        settle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/memory_access_unit.md
MEMORY_ACCESS_UNIT -- requirements
Module: memory_access_unit

Interface
REQ-001 SHALL have ports: clk input 1, system clock; single clock domain, all state updates on rising edge.
REQ-002 SHALL have: rst input 1, synchronous active-low reset, sampled on clk rising edge.
REQ-003 SHALL have: address_req input 64, byte address of access (ALU result).
REQ-004 SHALL have: data_in input 64, store source register value (rs2).
REQ-005 SHALL have: mem_mode input 3, access mode: 000 byte-signed, 001 half-signed, 010 word-signed, 011 double, 100 byte-unsigned, 101 half-unsigned, 110 word-unsigned, 111 reserved (treated as 011).
REQ-006 SHALL have: addr output 64, bus request address; msize output 3, size code 0=1B, 1=2B, 2=4B, 3=8B; strobe output 8, byte-lane write enables; data output 64, lane-aligned store data.
REQ-007 SHALL have: resp_valid input 1, bus response data valid; resp_data input 64, raw 8-byte-aligned bus read word.
REQ-008 SHALL have: load_data output 64, extracted and extended load result; misaligned output 1, access not naturally aligned.

Function
REQ-009 Request path SHALL be purely combinational from address_req/data_in/mem_mode: addr = address_req unmodified.
REQ-010 msize SHALL be 0 for modes 000/100, 1 for 001/101, 2 for 010/110, 3 for 011/111.
REQ-011 off = address_req[2:0]; strobe SHALL be base mask (0x01, 0x03, 0x0F, 0xFF per msize) shifted left by off, bits beyond lane 7 discarded.
REQ-012 data SHALL be data_in shifted left by 8*off, upper bits discarded; strobe is produced for every mode (caller zeroes it for loads).
REQ-013 Internal 64-bit capture register SHALL load resp_data on any rising edge with resp_valid=1 and rst=1; otherwise hold.
REQ-014 load_data SHALL be combinational from capture register and current address_req/mem_mode: shifted = reg >> 8*off, then byte/half/word taken from low bits.
REQ-015 Signed modes (000/001/010) SHALL sign-extend from bit 7/15/31; unsigned modes (100/101/110) SHALL zero-extend; 011/111 SHALL pass shifted value unchanged.
REQ-016 load_data SHALL reflect a response one cycle after resp_valid (no same-cycle bypass).
REQ-017 Back-to-back resp_valid SHALL overwrite capture register each cycle; last value wins.

Reset
REQ-018 With rst=0 at a rising edge, capture register SHALL clear to 0, so load_data = 0 for every mode; resp_valid during reset SHALL be ignored.
REQ-019 Request-path outputs SHALL remain combinational functions of inputs during reset; misaligned SHALL be 0 while rst=0.

Configuration
REQ-020 Macro MEM_MISALIGN_CHECK_EN: when defined, misaligned SHALL be a register updated every cycle to 1 iff address_req is not a multiple of the access size (2B: off[0]!=0; 4B: off[1:0]!=0; 8B: off!=0); when undefined, misaligned SHALL be constant 0 and no extra flop exists.

Verification
REQ-021 address_req=0x1003, mode 000, data_in=0xAB -> msize=0, strobe=0x08, data=0x00000000AB000000; then resp_data=0x00000000FF000000 with resp_valid -> next cycle load_data=0xFFFFFFFFFFFFFFFF; mode 100 -> 0x00000000000000FF.
REQ-022 address_req=0x2004, mode 010, data_in=0x1234567887654321 -> strobe=0xF0, data=0x8765432100000000; resp_data=0x8000000100000000 -> load_data=0xFFFFFFFF80000001; mode 110 -> 0x0000000080000001.
REQ-023 address_req=0x3006, mode 001, resp_data=0x7FFF000000000000 -> strobe=0xC0, load_data=0x0000000000007FFF; mode 011 at address 0x3000 -> strobe=0xFF, load_data=resp_data.
REQ-024 Capture 0xDEADBEEF, then rst=0 for one edge with resp_valid=1 -> load_data=0 after edge, register stays 0 until next valid response.
REQ-025 With MEM_MISALIGN_CHECK_EN: address 0x1002 mode 010 -> misaligned=1 next cycle; 0x1004 mode 010 -> 0; 0x1001 mode 000 -> 0; without macro all -> 0.
